// File: rtl/age_matrix_pkg.sv
// Shared helpers for the age-matrix arbiter family: index-width calculation
// and one-hot to binary encoding. Matrix row types depend on WIDTH and are
// therefore declared locally in each module.
package age_matrix_pkg;

   // Widest vector the encoder below accepts.
   localparam int MAX_WIDTH = 64;

   // Index width for n entries; never less than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // OR-encodes a one-hot vector. A zero vector encodes to 0.
   function automatic int unsigned onehot_to_idx(input logic [MAX_WIDTH-1:0] vec);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         if (vec[i]) idx = idx | unsigned'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/age_matrix_mp_if.sv
// Handshake bundle between an entry table and its oldest-first arbiter.
// master drives allocation/deallocation/requests; slave is the arbiter.
interface age_matrix_mp_if
   import age_matrix_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int ALLOC_PORTS = 2
) ();
   localparam int IDX_W = idx_w(WIDTH);

   logic [ALLOC_PORTS-1:0]       alloc_vld;
   logic [ALLOC_PORTS*IDX_W-1:0] alloc_idx;
   logic [WIDTH-1:0]             dealloc_vec;
   logic [WIDTH-1:0]             req_vec;
   logic [WIDTH-1:0]             entry_vld;
   logic [WIDTH-1:0]             gnt_vec;
   logic                         gnt_vld;
   logic [IDX_W-1:0]             gnt_idx;
   logic                         alloc_err;

   modport master (
      output alloc_vld, alloc_idx, dealloc_vec, req_vec,
      input  entry_vld, gnt_vec, gnt_vld, gnt_idx, alloc_err
   );

   modport slave (
      input  alloc_vld, alloc_idx, dealloc_vec, req_vec,
      output entry_vld, gnt_vec, gnt_vld, gnt_idx, alloc_err
   );
endinterface

// File: rtl/age_matrix_oldest.sv
// Combinational oldest-candidate picker. older is a full WIDTH x WIDTH
// matrix, row i at [i*WIDTH +: WIDTH], bit j set when i is older than j.
// A candidate wins when it is older than every other candidate.
module age_matrix_oldest #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]       cand,
   input  logic [WIDTH*WIDTH-1:0] older,
   output logic [WIDTH-1:0]       gnt
);

   // Per-row AND over all competing candidates; own column is masked out.
   always_comb begin
      // NOTE: default every combinational output first so no path infers a latch.
      gnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         gnt[i] = cand[i] & (&(older[i*WIDTH +: WIDTH] | ~cand | (WIDTH'(1) << i)));
      end
   end

endmodule

// File: rtl/age_matrix_mp.sv
// Multi-port age matrix: tracks allocation order of WIDTH entries with
// ALLOC_PORTS allocations per cycle and grants the oldest valid requester.
// Optional build macro: AGE_MATRIX_GNT_REG_EN registers the grant outputs
// (one cycle latency, grant dropped if its entry is freed that cycle).
module age_matrix_mp
   import age_matrix_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int ALLOC_PORTS = 2
) (
   input logic            clk,
   input logic            rst,
   age_matrix_mp_if.slave bus
);

   localparam int IDX_W  = idx_w(WIDTH);
   localparam int NPAIR  = WIDTH * (WIDTH - 1) / 2;
   localparam int RANK_W = idx_w(ALLOC_PORTS);

   // Upper-triangle storage: one bit per unordered pair (i<j), "i older than j".
   function automatic int pair(input int i, input int j);
      return i * WIDTH - (i * (i + 1)) / 2 + (j - i - 1);
   endfunction

   logic [WIDTH-1:0]       valid_q, valid_d;
   logic [NPAIR-1:0]       older_q, older_d;
   logic                   alloc_err_q;
   logic [WIDTH-1:0]       alloc_hit;
   logic [RANK_W-1:0]      alloc_rank [WIDTH];
   logic                   dup_err;
   logic                   realloc_err;
   logic [WIDTH*WIDTH-1:0] older_full;
   logic [WIDTH-1:0]       gnt_comb;

   // Per-entry allocation decode; the lowest port naming an entry sets its rank.
   always_comb begin
      alloc_hit = '0;
      dup_err   = 1'b0;
      for (int e = 0; e < WIDTH; e++) alloc_rank[e] = '0;
      for (int p = ALLOC_PORTS - 1; p >= 0; p--) begin
         for (int e = 0; e < WIDTH; e++) begin
            if (bus.alloc_vld[p] && bus.alloc_idx[p*IDX_W +: IDX_W] == IDX_W'(e)) begin
               alloc_hit[e]  = 1'b1;
               alloc_rank[e] = RANK_W'(p);
            end
         end
      end
      for (int p = 0; p < ALLOC_PORTS; p++) begin
         for (int q = p + 1; q < ALLOC_PORTS; q++) begin
            if (bus.alloc_vld[p] && bus.alloc_vld[q] &&
                bus.alloc_idx[p*IDX_W +: IDX_W] == bus.alloc_idx[q*IDX_W +: IDX_W])
               dup_err = 1'b1;
         end
      end
   end

   // Allocating a live entry that is not being freed is a protocol error.
   assign realloc_err = |(alloc_hit & valid_q & ~bus.dealloc_vec);
   // Alloc wins over a same-cycle dealloc of the same entry.
   assign valid_d     = (valid_q & ~bus.dealloc_vec) | alloc_hit;

   // New allocations become younger than all others; among themselves, port order.
   always_comb begin
      older_d = older_q;
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = i + 1; j < WIDTH; j++) begin
            if (alloc_hit[i] && alloc_hit[j])
               older_d[pair(i, j)] = (alloc_rank[i] < alloc_rank[j]);
            else if (alloc_hit[i])
               older_d[pair(i, j)] = 1'b0;
            else if (alloc_hit[j])
               older_d[pair(i, j)] = 1'b1;
         end
      end
   end

   // State registers; alloc_err is sticky until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q     <= '0;
         // NOTE: the matrix is reset too so the array never holds X in simulation.
         older_q     <= '0;
         alloc_err_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
         valid_q <= valid_d;
         older_q <= older_d;
         if (dup_err || realloc_err) alloc_err_q <= 1'b1;
      end
   end

   // Expand the triangle into a full antisymmetric matrix with a zero diagonal.
   always_comb begin
      older_full = '0;
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            if (i < j)      older_full[i*WIDTH + j] = older_q[pair(i, j)];
            else if (i > j) older_full[i*WIDTH + j] = ~older_q[pair(j, i)];
         end
      end
   end

   age_matrix_oldest #(.WIDTH(WIDTH)) u_oldest (
      .cand  (bus.req_vec & valid_q),
      .older (older_full),
      .gnt   (gnt_comb)
   );

   assign bus.entry_vld = valid_q;
   assign bus.alloc_err = alloc_err_q;

`ifdef AGE_MATRIX_GNT_REG_EN
   logic [WIDTH-1:0] gnt_q;
   logic             gnt_vld_q;
   logic [IDX_W-1:0] gnt_idx_q;
   logic [WIDTH-1:0] gnt_keep;

   assign gnt_keep = gnt_comb & ~bus.dealloc_vec;

   // Registered grant; an entry freed this cycle is not granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_q     <= '0;
         gnt_vld_q <= 1'b0;
         gnt_idx_q <= '0;
      end else begin
         gnt_q     <= gnt_keep;
         gnt_vld_q <= |gnt_keep;
         gnt_idx_q <= IDX_W'(onehot_to_idx(MAX_WIDTH'(gnt_keep)));
      end
   end

   assign bus.gnt_vec = gnt_q;
   assign bus.gnt_vld = gnt_vld_q;
   assign bus.gnt_idx = gnt_idx_q;
`else
   assign bus.gnt_vec = gnt_comb;
   assign bus.gnt_vld = |gnt_comb;
   assign bus.gnt_idx = IDX_W'(onehot_to_idx(MAX_WIDTH'(gnt_comb)));
`endif

endmodule

// File: tb/tb_age_matrix_mp.sv
// Directed and model-checked bench for age_matrix_mp (WIDTH=8, ALLOC_PORTS=2).
// Honours AGE_MATRIX_GNT_REG_EN by expecting grants one cycle later.
module tb_age_matrix_mp;
   localparam int WIDTH       = 8;
   localparam int ALLOC_PORTS = 2;
   localparam int IDX_W       = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   age_matrix_mp_if #(.WIDTH(WIDTH), .ALLOC_PORTS(ALLOC_PORTS)) bus ();

   age_matrix_mp #(.WIDTH(WIDTH), .ALLOC_PORTS(ALLOC_PORTS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;
   int order[$];   // age model: oldest entry first

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.alloc_vld   = '0;
      bus.alloc_idx   = '0;
      bus.dealloc_vec = '0;
   endtask

   task automatic alloc1(input logic [IDX_W-1:0] idx);
      bus.alloc_vld = 2'b01;
      bus.alloc_idx = {3'd0, idx};
      tick();
      idle();
   endtask

   // Applies a request vector and checks the grant it produces.
   task automatic check_grant(input string tag, input logic [WIDTH-1:0] req,
                              input logic exp_vld, input logic [IDX_W-1:0] exp_idx);
      bus.req_vec = req;
`ifdef AGE_MATRIX_GNT_REG_EN
      tick();
`endif
      #2;
      check({tag, "_vld"}, 32'(bus.gnt_vld), 32'(exp_vld));
      check({tag, "_idx"}, 32'(bus.gnt_idx), exp_vld ? 32'(exp_idx) : 32'd0);
      check({tag, "_vec"}, 32'(bus.gnt_vec), exp_vld ? (32'd1 << exp_idx) : 32'd0);
   endtask

   function automatic logic [WIDTH-1:0] model_gnt(input logic [WIDTH-1:0] req);
      for (int k = 0; k < order.size(); k++)
         if (req[order[k]]) return WIDTH'(1) << order[k];
      return '0;
   endfunction

   function automatic logic [WIDTH-1:0] model_valid();
      logic [WIDTH-1:0] v;
      v = '0;
      for (int k = 0; k < order.size(); k++) v[order[k]] = 1'b1;
      return v;
   endfunction

   task automatic model_update(input logic [WIDTH-1:0] dv, input logic [1:0] av,
                               input logic [IDX_W-1:0] i0, input logic [IDX_W-1:0] i1);
      int q_new[$];
      for (int k = 0; k < order.size(); k++) begin
         int e;
         e = order[k];
         if (!dv[e] && !(av[0] && i0 == IDX_W'(e)) && !(av[1] && i1 == IDX_W'(e)))
            q_new.push_back(e);
      end
      if (av[0]) q_new.push_back(int'(i0));
      if (av[1] && !(av[0] && i0 == i1)) q_new.push_back(int'(i1));
      order = q_new;
   endtask

   task automatic drive_cycle(input logic [WIDTH-1:0] dv, input logic [1:0] av,
                              input logic [IDX_W-1:0] i0, input logic [IDX_W-1:0] i1);
      bus.dealloc_vec = dv;
      bus.alloc_vld   = av;
      bus.alloc_idx   = {i1, i0};
      tick();
      model_update(dv, av, i0, i1);
      idle();
   endtask

   initial begin
      logic [WIDTH-1:0] dv, rq, exp_now, exp_prev;
      logic [1:0]       av;
      logic [IDX_W-1:0] i0, i1;
      bit               have_prev;

      idle();
      bus.req_vec = 8'hFF;
      #1;
      check("rst_entry_vld", 32'(bus.entry_vld), 32'd0);
      check("rst_gnt_vld",   32'(bus.gnt_vld),   32'd0);
      check("rst_alloc_err", 32'(bus.alloc_err), 32'd0);
      #2 rst = 1'b0;
      tick();

      // Successive single allocations: 3, 5, 1.
      alloc1(3'd3);
      alloc1(3'd5);
      alloc1(3'd1);
      check("seq_entry_vld", 32'(bus.entry_vld), 32'h2A);
      check_grant("seq_ff", 8'hFF, 1'b1, 3'd3);
      // Free 3 and the never-allocated 7.
      bus.dealloc_vec = 8'h88;
      tick();
      idle();
      check("dealloc_entry_vld", 32'(bus.entry_vld), 32'h22);
      check_grant("after_dealloc", 8'hFF, 1'b1, 3'd5);

      // Dual-port allocation: port0 6 is older than port1 2. Order 5,1,6,2.
      bus.alloc_vld = 2'b11;
      bus.alloc_idx = {3'd2, 3'd6};
      tick();
      idle();
      check_grant("dual_44", 8'h44, 1'b1, 3'd6);
      check_grant("dual_04", 8'h04, 1'b1, 3'd2);
      check_grant("dual_66", 8'h66, 1'b1, 3'd5);
      check_grant("dual_46", 8'h46, 1'b1, 3'd1);
      check_grant("none_req", 8'h88, 1'b0, 3'd0);

      // Order 5,1,6,2,0 then alloc+dealloc 4 together.
      alloc1(3'd0);
      bus.dealloc_vec = 8'h10;
      alloc1(3'd4);
      check("ad4_entry_vld", 32'(bus.entry_vld), 32'h77);
      check_grant("ad4_11", 8'h11, 1'b1, 3'd0);
      check("ad4_alloc_err", 32'(bus.alloc_err), 32'd0);
      // Alloc+dealloc of live entry 5: legal, 5 becomes youngest. Order 1,6,2,0,4,5.
      bus.dealloc_vec = 8'h20;
      alloc1(3'd5);
      check_grant("ad5_22", 8'h22, 1'b1, 3'd1);
      check("ad5_alloc_err", 32'(bus.alloc_err), 32'd0);

      // Re-allocating live 0 without dealloc: error, 0 youngest. Order 1,6,2,4,5,0.
      alloc1(3'd0);
      check("realloc_err", 32'(bus.alloc_err), 32'd1);
      check_grant("realloc_11", 8'h11, 1'b1, 3'd4);
      tick();
      tick();
      check("err_sticky", 32'(bus.alloc_err), 32'd1);

      // Same-cycle dealloc does not mask a combinational grant.
      bus.dealloc_vec = 8'h02;
      bus.req_vec     = 8'h02;
`ifdef AGE_MATRIX_GNT_REG_EN
      tick();
      idle();
      #2;
      check("dealloc_suppress", 32'(bus.gnt_vld), 32'd0);
`else
      #2;
      check("dealloc_nomask", 32'(bus.gnt_idx), 32'd1);
      check("dealloc_nomask_vld", 32'(bus.gnt_vld), 32'd1);
      tick();
      idle();
`endif
      check("dealloc1_entry_vld", 32'(bus.entry_vld), 32'h75);

      // Asynchronous reset in the middle of traffic.
      bus.req_vec   = 8'hFF;
      bus.alloc_vld = 2'b01;
      bus.alloc_idx = {3'd0, 3'd3};
      #2 rst = 1'b1;
      #1;
      check("async_entry_vld", 32'(bus.entry_vld), 32'd0);
      check("async_gnt_vld",   32'(bus.gnt_vld),   32'd0);
      check("async_alloc_err", 32'(bus.alloc_err), 32'd0);
      idle();
      #2 rst = 1'b0;
      tick();

      // Two ports allocate 3 together after 7: error, 7 stays oldest.
      alloc1(3'd7);
      bus.alloc_vld = 2'b11;
      bus.alloc_idx = {3'd3, 3'd3};
      tick();
      idle();
      check("dup_alloc_err", 32'(bus.alloc_err), 32'd1);
      check("dup_entry_vld", 32'(bus.entry_vld), 32'h88);
      check_grant("dup_88", 8'h88, 1'b1, 3'd7);

      // Fill all entries, then model-checked traffic.
      rst = 1'b1;
      #1 rst = 1'b0;
      tick();
      order.delete();
      drive_cycle('0, 2'b11, 3'd0, 3'd1);
      drive_cycle('0, 2'b11, 3'd2, 3'd3);
      drive_cycle('0, 2'b11, 3'd4, 3'd5);
      drive_cycle('0, 2'b11, 3'd6, 3'd7);
      check("full_entry_vld", 32'(bus.entry_vld), 32'hFF);

      have_prev = 1'b0;
      exp_prev  = '0;
      for (int c = 0; c < 2000; c++) begin
         dv = WIDTH'($urandom) & WIDTH'($urandom) & WIDTH'($urandom);
         av = 2'($urandom);
         i0 = IDX_W'($urandom);
         i1 = IDX_W'($urandom);
         rq = WIDTH'($urandom);
         bus.dealloc_vec = dv;
         bus.alloc_vld   = av;
         bus.alloc_idx   = {i1, i0};
         bus.req_vec     = rq;
         #2;
         exp_now = model_gnt(rq);
`ifdef AGE_MATRIX_GNT_REG_EN
         if (have_prev) check("rand_gnt", 32'(bus.gnt_vec), 32'(exp_prev));
         exp_prev  = exp_now & ~dv;
         have_prev = 1'b1;
`else
         check("rand_gnt", 32'(bus.gnt_vec), 32'(exp_now));
`endif
         check("rand_entry_vld", 32'(bus.entry_vld), 32'(model_valid()));
         check("rand_onehot", 32'($onehot0(bus.gnt_vec)), 32'd1);
         model_update(dv, av, i0, i1);
         tick();
      end
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
